// File: rtl/metronome_pkg.sv
// Shared types and constants for the metronome tempo controller.
package metronome_pkg;

   localparam int BPM_W = 8;

   typedef logic [3:0] bcd_digit_t;

   localparam logic [BPM_W-1:0] BPM_MIN_DEF   = 8'd40;
   localparam logic [BPM_W-1:0] BPM_MAX_DEF   = 8'd240;
   localparam logic [BPM_W-1:0] BPM_RESET_DEF = 8'd120;

   typedef enum logic [1:0] {
      CONV_IDLE,
      CONV_SHIFT,
      CONV_DONE
   } conv_state_t;

   // Double-dabble correction: a nibble of 5 or more would overflow past 9 when doubled
   function automatic bcd_digit_t add3(input bcd_digit_t n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one input bit per cycle.
// A start pulse at any time reloads the value and restarts the conversion.
module bin_to_bcd_seq
   import metronome_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [BPM_W-1:0] value,
   output logic             busy,
   output logic             done,
   output bcd_digit_t       digit_100,
   output bcd_digit_t       digit_10,
   output bcd_digit_t       digit_1
);

   localparam int NIB   = 3;
   localparam int SCR_W = 4 * NIB + BPM_W;
   localparam int CNT_W = $clog2(BPM_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BPM_W - 1);

   conv_state_t      state_reg;
   logic [SCR_W-1:0] scratch_reg;
   logic [SCR_W-1:0] adjusted;
   logic [CNT_W-1:0] bit_cnt_reg;

   // BCD field sits above the binary field; every nibble is corrected before each shift
   assign adjusted[BPM_W-1:0] = scratch_reg[BPM_W-1:0];
   generate
      for (genvar gi = 0; gi < NIB; gi++) begin : g_adj
         assign adjusted[BPM_W + 4*gi +: 4] = add3(scratch_reg[BPM_W + 4*gi +: 4]);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= CONV_IDLE;
         scratch_reg <= '0;
         bit_cnt_reg <= '0;
         digit_100   <= '0;
         digit_10    <= '0;
         digit_1     <= '0;
      end else if (start) begin
         state_reg   <= CONV_SHIFT;
         scratch_reg <= {{(4*NIB){1'b0}}, value};
         bit_cnt_reg <= '0;
      end else begin
         case (state_reg)
            CONV_SHIFT: begin
               scratch_reg <= adjusted << 1;
               bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
               if (bit_cnt_reg == LAST_BIT) begin
                  state_reg <= CONV_DONE;
               end
            end
            CONV_DONE: begin
               digit_100 <= scratch_reg[BPM_W + 8 +: 4];
               digit_10  <= scratch_reg[BPM_W + 4 +: 4];
               digit_1   <= scratch_reg[BPM_W     +: 4];
               state_reg <= CONV_IDLE;
            end
            default: state_reg <= CONV_IDLE;
         endcase
      end
   end

   assign busy = (state_reg != CONV_IDLE);
   assign done = (state_reg == CONV_DONE);

endmodule

// File: rtl/bpm_tempo_ctrl.sv
// Metronome tempo register: inc/dec buttons step bpm with hold-to-repeat, and each new value
// is converted to BCD digits. Define BPM_WRAP_EN to wrap at the limits instead of clamping.
module bpm_tempo_ctrl
   import metronome_pkg::*;
#(
   parameter logic [BPM_W-1:0] BPM_MIN       = BPM_MIN_DEF,
   parameter logic [BPM_W-1:0] BPM_MAX       = BPM_MAX_DEF,
   parameter logic [BPM_W-1:0] BPM_RESET     = BPM_RESET_DEF,
   parameter int               HOLD_CYCLES   = 25_000_000,
   parameter int               REPEAT_CYCLES = 5_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_btn,
   input  logic             dec_btn,
   output logic [BPM_W-1:0] bpm,
   output logic             bpm_changed,
   output logic [3:0]       digit_100,
   output logic [3:0]       digit_10,
   output logic [3:0]       digit_1,
   output logic             bcd_valid
);

   localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] HOLD_LIM   = CNT_W'(HOLD_CYCLES);
   localparam logic [CNT_W-1:0] REPEAT_LIM = CNT_W'(REPEAT_CYCLES);
   localparam logic [BPM_W:0]   STEP_ONE   = 1;

   logic             inc_reg, dec_reg, inc_prev_reg, dec_prev_reg;
   logic [BPM_W-1:0] bpm_reg;
   logic             bpm_changed_reg, bcd_valid_reg, armed_reg, repeat_reg;
   logic [CNT_W-1:0] hold_cnt_reg;

   logic             act_inc, act_dec, acting, rise;
   logic             step_req, update;
   logic [BPM_W:0]   sum;
   logic [BPM_W-1:0] target, bpm_next;
   logic [CNT_W-1:0] limit;
   logic             conv_start, conv_busy, conv_done;

   assign act_inc = inc_reg & ~dec_reg;
   assign act_dec = dec_reg & ~inc_reg;
   assign acting  = act_inc | act_dec;
   assign rise    = (act_inc & ~inc_prev_reg) | (act_dec & ~dec_prev_reg);

   always_comb begin
      sum = act_inc ? ({1'b0, bpm_reg} + STEP_ONE) : ({1'b0, bpm_reg} - STEP_ONE);
`ifdef BPM_WRAP_EN
      if (sum > {1'b0, BPM_MAX}) begin
         target = BPM_MIN;
      end else if (sum < {1'b0, BPM_MIN}) begin
         target = BPM_MAX;
      end else begin
         target = sum[BPM_W-1:0];
      end
`else
      if (sum > {1'b0, BPM_MAX}) begin
         target = BPM_MAX;
      end else if (sum < {1'b0, BPM_MIN}) begin
         target = BPM_MIN;
      end else begin
         target = sum[BPM_W-1:0];
      end
`endif
      // Counter restarts at 1 after every step so it equals the cycles elapsed since that step
      limit    = repeat_reg ? REPEAT_LIM : HOLD_LIM;
      step_req = acting & (rise | (hold_cnt_reg == limit));
      update   = step_req & (target != bpm_reg);
      bpm_next = update ? target : bpm_reg;
   end

   assign conv_start = armed_reg | update;

   always_ff @(posedge clk) begin
      if (rst) begin
         inc_reg         <= 1'b0;
         dec_reg         <= 1'b0;
         inc_prev_reg    <= 1'b0;
         dec_prev_reg    <= 1'b0;
         bpm_reg         <= BPM_RESET;
         bpm_changed_reg <= 1'b0;
         bcd_valid_reg   <= 1'b0;
         armed_reg       <= 1'b1;
         hold_cnt_reg    <= '0;
         repeat_reg      <= 1'b0;
      end else begin
         inc_reg         <= inc_btn;
         dec_reg         <= dec_btn;
         inc_prev_reg    <= inc_reg;
         dec_prev_reg    <= dec_reg;
         armed_reg       <= 1'b0;
         bpm_reg         <= bpm_next;
         bpm_changed_reg <= update;

         if (conv_start) begin
            bcd_valid_reg <= 1'b0;
         end else if (conv_done) begin
            bcd_valid_reg <= 1'b1;
         end else if (conv_busy) begin
            bcd_valid_reg <= 1'b0;
         end

         if (!acting) begin
            hold_cnt_reg <= '0;
            repeat_reg   <= 1'b0;
         end else if (step_req) begin
            hold_cnt_reg <= CNT_W'(1);
            repeat_reg   <= ~rise;
         end else begin
            hold_cnt_reg <= hold_cnt_reg + CNT_W'(1);
         end
      end
   end

   bin_to_bcd_seq u_bcd (
      .clk       (clk),
      .rst       (rst),
      .start     (conv_start),
      .value     (bpm_next),
      .busy      (conv_busy),
      .done      (conv_done),
      .digit_100 (digit_100),
      .digit_10  (digit_10),
      .digit_1   (digit_1)
   );

   assign bpm         = bpm_reg;
   assign bpm_changed = bpm_changed_reg;
   assign bcd_valid   = bcd_valid_reg;

endmodule

// File: tb/tb_bpm_tempo_ctrl.sv
// Self-checking bench for bpm_tempo_ctrl: directed vectors, corner sequences and random
// button activity compared every cycle against a press-timeline reference model.
module tb_bpm_tempo_ctrl;

   localparam int H = 20;
   localparam int R = 5;

   typedef struct {
      bit inc;
      bit dec;
      int len;
      int exp_bpm;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       inc_btn = 1'b0;
   logic       dec_btn = 1'b0;
   logic [7:0] bpm;
   logic       bpm_changed;
   logic [3:0] digit_100, digit_10, digit_1;
   logic       bcd_valid;

   int checks = 0;
   int errors = 0;

   // Reference model: press age in cycles, conversion age in cycles since the last new value
   int m_bpm, m_conv, m_t, m_age, m_d100, m_d10, m_d1;
   bit m_changed, m_valid, m_armed, m_i, m_d, m_pi, m_pd;

   bpm_tempo_ctrl #(
      .HOLD_CYCLES   (H),
      .REPEAT_CYCLES (R)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .inc_btn     (inc_btn),
      .dec_btn     (dec_btn),
      .bpm         (bpm),
      .bpm_changed (bpm_changed),
      .digit_100   (digit_100),
      .digit_10    (digit_10),
      .digit_1     (digit_1),
      .bcd_valid   (bcd_valid)
   );

   always #5 clk = ~clk;

   function automatic int next_bpm(int b, bit up);
`ifdef BPM_WRAP_EN
      if (up) return (b >= 240) ? 40 : b + 1;
      return (b <= 40) ? 240 : b - 1;
`else
      if (up) return (b >= 240) ? 240 : b + 1;
      return (b <= 40) ? 40 : b - 1;
`endif
   endfunction

   function automatic int bcd_of(int b);
      return ((b / 100) << 8) | (((b / 10) % 10) << 4) | (b % 10);
   endfunction

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic model_edge(bit r, bit i, bit d);
      bit ai, ad, rising, fire;
      int nb;
      if (r) begin
         m_bpm = 120; m_changed = 0; m_valid = 0; m_armed = 1;
         m_d100 = 0; m_d10 = 0; m_d1 = 0; m_conv = 0;
         m_age = -1; m_t = -1;
         m_i = 0; m_d = 0; m_pi = 0; m_pd = 0;
         return;
      end
      ai = m_i && !m_d;
      ad = m_d && !m_i;
      fire = 0;
      if (!(ai || ad)) begin
         m_t = -1;
      end else begin
         rising = ai ? !m_pi : !m_pd;
         m_t = rising ? 0 : m_t + 1;
         fire = rising || (m_t >= H && ((m_t - H) % R) == 0);
      end
      nb = fire ? next_bpm(m_bpm, ai) : m_bpm;
      m_changed = (nb != m_bpm);
      if (m_changed || m_armed) begin
         m_age = 0; m_conv = nb; m_valid = 0;
      end else if (m_age >= 0) begin
         m_age++;
         if (m_age == 9) begin
            m_d100 = m_conv / 100; m_d10 = (m_conv / 10) % 10; m_d1 = m_conv % 10;
            m_valid = 1; m_age = -1;
         end
      end
      m_bpm = nb;
      m_armed = 0;
      m_pi = m_i; m_pd = m_d; m_i = i; m_d = d;
   endtask

   task automatic cyc(bit r, bit i, bit d);
      rst = r; inc_btn = i; dec_btn = d;
      @(posedge clk);
      model_edge(r, i, d);
      #1;
      chk("model_bpm", bpm, m_bpm);
      chk("model_changed", bpm_changed, m_changed);
      chk("model_valid", bcd_valid, m_valid);
      chk("model_d100", digit_100, m_d100);
      chk("model_d10", digit_10, m_d10);
      chk("model_d1", digit_1, m_d1);
   endtask

   initial begin
      vec_t vecs[6];
      bit   ri, rd;
      int   c;
      vecs[0] = '{inc: 1'b0, dec: 1'b1, len: 36, exp_bpm: 115};
      vecs[1] = '{inc: 1'b1, dec: 1'b0, len: 1,  exp_bpm: 116};
      vecs[2] = '{inc: 1'b1, dec: 1'b0, len: 21, exp_bpm: 118};
      vecs[3] = '{inc: 1'b0, dec: 1'b1, len: 20, exp_bpm: 117};
      vecs[4] = '{inc: 1'b1, dec: 1'b1, len: 10, exp_bpm: 117};
      vecs[5] = '{inc: 1'b1, dec: 1'b0, len: 26, exp_bpm: 120};

      // Reset state, then first conversion after release
      repeat (3) cyc(1, 0, 0);
      chk("rst_bpm", bpm, 120);
      chk("rst_valid", bcd_valid, 0);
      chk("rst_digits", {digit_100, digit_10, digit_1}, 0);
      for (int k = 0; k <= 9; k++) begin
         cyc(0, 0, 0);
         chk("release_valid", bcd_valid, (k == 9) ? 1 : 0);
      end
      chk("release_digits", {digit_100, digit_10, digit_1}, 12'h120);

      // Single increment press
      cyc(0, 1, 0);
      chk("inc_reg_edge_bpm", bpm, 120);
      cyc(0, 0, 0);
      chk("inc_bpm", bpm, 121);
      chk("inc_pulse", bpm_changed, 1);
      for (int k = 1; k <= 9; k++) begin
         cyc(0, 0, 0);
         chk("inc_pulse_len", bpm_changed, 0);
         chk("inc_valid", bcd_valid, (k == 9) ? 1 : 0);
      end
      chk("inc_digits", {digit_100, digit_10, digit_1}, 12'h121);

      // Directed press table from the reset tempo
      repeat (2) cyc(1, 0, 0);
      repeat (12) cyc(0, 0, 0);
      for (int v = 0; v < 6; v++) begin
         repeat (vecs[v].len) cyc(0, vecs[v].inc, vecs[v].dec);
         repeat (12) cyc(0, 0, 0);
         chk("vec_bpm", bpm, vecs[v].exp_bpm);
         chk("vec_valid", bcd_valid, 1);
         chk("vec_digits", {digit_100, digit_10, digit_1}, bcd_of(vecs[v].exp_bpm));
      end

      // Second update while the first conversion is still shifting
      cyc(0, 1, 0);
      cyc(0, 0, 0);
      chk("abort_first", bpm, 121);
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      cyc(0, 1, 0);
      cyc(0, 0, 0);
      chk("abort_second", bpm, 122);
      for (int k = 1; k <= 9; k++) begin
         cyc(0, 0, 0);
         if (k < 9) begin
            chk("abort_valid_low", bcd_valid, 0);
            chk("abort_digits_held", {digit_100, digit_10, digit_1}, 12'h120);
         end else begin
            chk("abort_valid", bcd_valid, 1);
            chk("abort_digits", {digit_100, digit_10, digit_1}, 12'h122);
         end
      end

      // Both buttons at 99, then reset during a conversion
      for (int k = 0; k < 400 && m_bpm != 99; k++) cyc(0, 0, 1);
      repeat (12) cyc(0, 0, 0);
      chk("reach_99", bpm, 99);
      repeat (30) cyc(0, 1, 1);
      repeat (3) cyc(0, 0, 0);
      chk("both_bpm", bpm, 99);
      chk("both_valid", bcd_valid, 1);
      cyc(0, 1, 0);
      cyc(0, 0, 0);
      chk("pre_rst_bpm", bpm, 100);
      repeat (3) cyc(0, 0, 0);
      chk("mid_conv_valid", bcd_valid, 0);
      cyc(1, 0, 0);
      chk("rst_mid_bpm", bpm, 120);
      chk("rst_mid_valid", bcd_valid, 0);
      chk("rst_mid_changed", bpm_changed, 0);
      chk("rst_mid_digits", {digit_100, digit_10, digit_1}, 0);

      // Upper limit
      repeat (12) cyc(0, 0, 0);
      for (int k = 0; k < 1000 && m_bpm != 240; k++) cyc(0, 1, 0);
      repeat (12) cyc(0, 0, 0);
      chk("reach_240", bpm, 240);
      chk("max_digits", {digit_100, digit_10, digit_1}, 12'h240);
      cyc(0, 1, 0);
      cyc(0, 0, 0);
`ifdef BPM_WRAP_EN
      chk("max_inc_bpm", bpm, 40);
      chk("max_inc_pulse", bpm_changed, 1);
      repeat (9) cyc(0, 0, 0);
      chk("max_inc_valid", bcd_valid, 1);
      chk("max_inc_digits", {digit_100, digit_10, digit_1}, 12'h040);
`else
      chk("max_inc_bpm", bpm, 240);
      chk("max_inc_pulse", bpm_changed, 0);
      chk("max_inc_no_conv", bcd_valid, 1);
      repeat (9) cyc(0, 0, 0);
      chk("max_inc_digits", {digit_100, digit_10, digit_1}, 12'h240);
`endif

      // Lower limit
      repeat (2) cyc(1, 0, 0);
      repeat (12) cyc(0, 0, 0);
      for (int k = 0; k < 1000 && m_bpm != 40; k++) cyc(0, 0, 1);
      repeat (12) cyc(0, 0, 0);
      chk("reach_40", bpm, 40);
      cyc(0, 0, 1);
      cyc(0, 0, 0);
`ifdef BPM_WRAP_EN
      chk("min_dec_bpm", bpm, 240);
      chk("min_dec_pulse", bpm_changed, 1);
`else
      chk("min_dec_bpm", bpm, 40);
      chk("min_dec_pulse", bpm_changed, 0);
      chk("min_dec_no_conv", bcd_valid, 1);
`endif
      repeat (12) cyc(0, 0, 0);

      // Random button activity with occasional resets
      ri = 0;
      rd = 0;
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(39) == 0) begin
            c  = $urandom_range(3);
            ri = c[0];
            rd = c[1];
         end
         cyc(($urandom_range(599) == 0), ri, rd);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
